// File: rtl/maf_pkg.sv
// ============================================================================
//  Module      : maf_pkg
//  Description : Shared types and helpers for the I/Q moving-average filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maf_pkg;

    typedef enum logic [1:0] {
        MAF_EMPTY = 2'd0,
        MAF_FILL  = 2'd1,
        MAF_FULL  = 2'd2
    } maf_state_e;

    // Running sum of N = 2**LOG2_N samples needs LOG2_N guard bits.
    function automatic int acc_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maf_iq_filter_if.sv
// ============================================================================
//  Module      : maf_iq_filter_if
//  Description : Sample/average stream bundle for the I/Q moving-average filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maf_iq_filter_if #(
    parameter int DATA_W = 16
);
    logic                     clear;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_i;
    logic signed [DATA_W-1:0] in_q;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_i;
    logic signed [DATA_W-1:0] out_q;
    logic                     primed;

    modport master (
        output clear, in_valid, in_i, in_q,
        input  out_valid, out_i, out_q, primed
    );

    modport slave (
        input  clear, in_valid, in_i, in_q,
        output out_valid, out_i, out_q, primed
    );
endinterface

`default_nettype wire

// File: rtl/maf_channel.sv
// ============================================================================
//  Module      : maf_channel
//  Description : One moving-average channel: history ring, running sum and
//                registered average. Build macro MAF_ROUND_EN selects
//                round-half-up instead of floor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maf_channel
    import maf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_clear,
    input  wire logic                     i_accept,
    input  wire logic [LOG2_N-1:0]        i_wr_ptr,
    input  wire logic signed [DATA_W-1:0] i_din,
    output logic signed [DATA_W-1:0]      o_dout
);

    localparam int c_N     = 1 << LOG2_N;
    localparam int c_ACC_W = acc_w(DATA_W, LOG2_N);

    logic signed [DATA_W-1:0] r_hist [c_N];
    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [DATA_W-1:0]  r_dout;

    logic signed [DATA_W-1:0]  w_oldest;
    logic signed [c_ACC_W-1:0] w_din_ext;
    logic signed [c_ACC_W-1:0] w_old_ext;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic signed [DATA_W-1:0]  w_avg;

    assign w_oldest   = r_hist[i_wr_ptr];
    assign w_din_ext  = {{LOG2_N{i_din[DATA_W-1]}}, i_din};
    assign w_old_ext  = {{LOG2_N{w_oldest[DATA_W-1]}}, w_oldest};
    assign w_acc_next = r_acc + w_din_ext - w_old_ext;

`ifdef MAF_ROUND_EN
    // floor((a + 2**(k-1)) / 2**k) == floor(a / 2**k) + a[k-1]; the sum
    // never leaves the DATA_W range, so no wider intermediate is kept.
    assign w_avg = w_acc_next[c_ACC_W-1:LOG2_N] + DATA_W'(w_acc_next[LOG2_N-1]);
`else
    assign w_avg = w_acc_next[c_ACC_W-1:LOG2_N];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_dout <= '0;
            for (int k = 0; k < c_N; k++) r_hist[k] <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            for (int k = 0; k < c_N; k++) r_hist[k] <= '0;
        end else if (i_accept) begin
            r_acc            <= w_acc_next;
            r_hist[i_wr_ptr] <= i_din;
            r_dout           <= w_avg;
        end
    end

    assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/maf_iq_filter.sv
// ============================================================================
//  Module      : maf_iq_filter
//  Description : Two-channel (I/Q) power-of-two moving-average filter with fill
//                tracking. Build macro MAF_ROUND_EN enables rounded output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maf_iq_filter
    import maf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input wire logic     clk,
    input wire logic     rst,
    maf_iq_filter_if.slave bus
);

    localparam logic [LOG2_N-1:0] c_PTR_LAST = '1;

    maf_state_e        r_state;
    logic [LOG2_N-1:0] r_wr_ptr;
    logic              r_out_valid;
    logic              r_primed;
    logic              w_accept;

    // A clear in the same cycle as a sample drops the sample.
    assign w_accept = bus.in_valid & ~bus.clear;

    // wr_ptr starts at zero after every flush, so it doubles as the fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MAF_EMPTY;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (bus.clear) begin
                r_state  <= MAF_EMPTY;
                r_wr_ptr <= '0;
                r_primed <= 1'b0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                case (r_state)
                    MAF_EMPTY: r_state <= MAF_FILL;
                    MAF_FILL: begin
                        if (r_wr_ptr == c_PTR_LAST) begin
                            r_state  <= MAF_FULL;
                            r_primed <= 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    maf_channel #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_chan_i (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (bus.clear),
        .i_accept (w_accept),
        .i_wr_ptr (r_wr_ptr),
        .i_din    (bus.in_i),
        .o_dout   (bus.out_i)
    );

    maf_channel #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_chan_q (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (bus.clear),
        .i_accept (w_accept),
        .i_wr_ptr (r_wr_ptr),
        .i_din    (bus.in_q),
        .o_dout   (bus.out_q)
    );

    assign bus.out_valid = r_out_valid;
    assign bus.primed    = r_primed;

endmodule

`default_nettype wire

// File: tb/tb_maf_iq_filter.sv
// ============================================================================
//  Module      : tb_maf_iq_filter
//  Description : Directed vector-table bench for maf_iq_filter (16-sample window).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maf_iq_filter;

    localparam int DATA_W = 16;
    localparam int LOG2_N = 4;
    localparam int N      = 16;

    logic clk = 1'b0;
    logic rst;

    maf_iq_filter_if #(.DATA_W(DATA_W)) bus ();

    maf_iq_filter #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic clr;
        logic vld;
        int   i;
        int   q;
        logic ov;
        int   ei;
        int   eq;
        logic ep;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    // Expected average of a window sum over N = 16 samples.
    function automatic int avg(input int sum);
`ifdef MAF_ROUND_EN
        return (sum + N / 2) >>> LOG2_N;
`else
        return sum >>> LOG2_N;
`endif
    endfunction

    function automatic void add(input logic clr, input logic vld, input int i, input int q,
                                input logic ov, input int ei, input int eq, input logic ep);
        vec_t v;
        v.clr = clr; v.vld = vld; v.i = i; v.q = q;
        v.ov = ov; v.ei = ei; v.eq = eq; v.ep = ep;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic drive(input logic clr, input logic vld, input int i, input int q);
        bus.clear    = clr;
        bus.in_valid = vld;
        bus.in_i     = 16'(i);
        bus.in_q     = 16'(q);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ov, input int ei, input int eq, input logic ep);
        chk({nm, " out_valid"}, int'(bus.out_valid), int'(ov));
        chk({nm, " out_i"}, int'(bus.out_i), ei);
        chk({nm, " out_q"}, int'(bus.out_q), eq);
        chk({nm, " primed"}, int'(bus.primed), int'(ep));
    endtask

    initial begin
        int m;

        // Ramp fill from reset
        for (int k = 1; k <= N; k++) add(0, 1, 16, -16, 1, avg(16 * k), avg(-16 * k), k == N);
        add(1, 0, 0, 0, 0, avg(16 * N), avg(-16 * N), 0);
        // Wrap-around: pointer wraps twice
        for (int k = 1; k <= 40; k++) begin
            m = (k < N) ? k : N;
            add(0, 1, 100, -100, 1, avg(100 * m), avg(-100 * m), k >= N);
        end
        add(0, 0, 7, 7, 0, 100, avg(-1600), 1);
        add(1, 0, 0, 0, 0, 100, avg(-1600), 0);
        // Step down from a full window of 1000
        for (int k = 1; k <= N; k++) add(0, 1, 1000, 1000, 1, avg(1000 * k), avg(1000 * k), k == N);
        add(0, 1, 0, 0, 1, avg(15000), avg(15000), 1);
        add(1, 0, 0, 0, 0, avg(15000), avg(15000), 0);
        // Single negative sample into an empty window
        add(0, 1, -8, -8, 1, avg(-8), avg(-8), 0);

        rst = 1'b1;
        drive(0, 0, 0, 0);
        #12;
        chk_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        foreach (tbl[n]) begin
            drive(tbl[n].clr, tbl[n].vld, tbl[n].i, tbl[n].q);
            step();
            chk_out($sformatf("vec%0d", n), tbl[n].ov, tbl[n].ei, tbl[n].eq, tbl[n].ep);
        end

        // Gapped input: one accept every third cycle
        drive(1, 0, 0, 0);
        step();
        for (int k = 1; k <= N; k++) begin
            for (int c = 0; c < 3; c++) begin
                drive(0, c == 0, 32, 32);
                step();
                chk_out($sformatf("gap%0d.%0d", k, c), c == 0, avg(32 * k), avg(32 * k), k == N);
            end
        end

        // Clear and sample together: clear wins
        drive(1, 1, 500, 500);
        step();
        chk_out("collide", 0, 32, 32, 0);
        drive(0, 1, 160, 160);
        step();
        chk_out("post_clear", 1, 10, 10, 0);

        // Asynchronous reset mid-fill
        drive(1, 0, 0, 0);
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 16, 16);
            step();
        end
        chk_out("pre_rst", 1, 3, 3, 0);
        drive(0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        step();
        for (int k = 1; k <= N; k++) begin
            drive(0, 1, 16, -16);
            step();
            chk_out($sformatf("restart%0d", k), 1, avg(16 * k), avg(-16 * k), k == N);
        end
        drive(0, 0, 0, 0);
        step();
        chk_out("restart_idle", 0, avg(16 * N), avg(-16 * N), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/maf_iq_filter.md
# maf_iq_filter

Parametrised two-channel (I/Q) moving-average filter for the QAM receive path, placed after the demodulator mixers to suppress the double-frequency products ahead of the symbol slicer. It averages a power-of-two window of signed samples per channel using a running sum (add newest, subtract oldest) over a circular history buffer. Flow is controlled by a valid strobe. A fill state machine reports when the window holds a full set of real samples.

## Interface
- DATA_W, 16, signed sample width of I, Q in and out
- LOG2_N, 4, log2 of window depth; N = 2**LOG2_N, legal 1..8
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush of history, sum and fill state
- in_valid  in  1  sample strobe; in_i/in_q accepted when high
- in_i  in  DATA_W  signed I sample
- in_q  in  DATA_W  signed Q sample
- out_valid  out  1  one-cycle strobe, new average on out_i/out_q
- out_i  out  DATA_W  signed I average
- out_q  out  DATA_W  signed Q average
- primed  out  1  high while the window holds N real samples

## Operation
- Per channel: history buffer hist[0..N-1] (DATA_W), write pointer wr_ptr (LOG2_N bits, shared), running sum acc (DATA_W+LOG2_N bits, signed).
- On accept: oldest = hist[wr_ptr]; acc <= acc + sext(in) - sext(oldest); hist[wr_ptr] <= in; wr_ptr <= wr_ptr+1 (wraps N-1 -> 0).
- Output = (acc_next) >>> LOG2_N, arithmetic shift, floor toward -inf; result always fits DATA_W, no saturation needed.
- History is zero after reset/clear, so the partial window averages against zeros (output ramps up).
- FSM (shared): EMPTY -> FILL on first accept; FILL counts accepts, -> FULL on the N-th accept; FULL stays until clear/rst. primed = (state == FULL).
- clear: acc, wr_ptr, fill count, all hist entries -> 0; state -> EMPTY. clear with in_valid in the same cycle: clear wins, sample dropped, out_valid stays low.
- in_valid low: no state change; out_i/out_q hold their last value.

## Timing
- Reset values: out_valid 0, out_i 0, out_q 0, primed 0; acc, wr_ptr, hist all 0; state EMPTY.
- Latency 1: sample accepted at edge k -> out_valid high and average, including that sample, visible after edge k; out_valid high for exactly one cycle per accept.
- Throughput: one sample per cycle, back-to-back in_valid sustained indefinitely.
- primed rises together with the out_valid of the N-th accepted sample.
- rst asserted mid-stream: all state cleared immediately, independent of clk; first accept after release starts a new FILL.

## Configuration
- MAF_ROUND_EN defined: output = (acc_next + 2**(LOG2_N-1)) >>> LOG2_N, computed in DATA_W+LOG2_N+1 bits (round half up). The result cannot exceed the DATA_W range.
- MAF_ROUND_EN undefined: plain truncating arithmetic shift, as above. Latency is unchanged in both builds.

## Structure
- Package maf_pkg: FSM state enum (MAF_EMPTY, MAF_FILL, MAF_FULL), accumulator width function acc_w(DATA_W, LOG2_N).
- Sub-module maf_channel: one instance each for I and Q. It holds hist, acc and the output register, and takes the shared wr_ptr, accept and clear. Top level holds the FSM, wr_ptr and primed.

## Test plan
- Ramp fill: rst, then 16 back-to-back samples I=16, Q=-16 -> out_i = 1,2,…,16 and out_q = -1,…,-16. primed rises with the 16th out_valid.
- Wrap-around: 40 samples I=100 -> out_i = 100 from sample 16 through 40, constant. wr_ptr wraps twice with no glitch.
- Step/rounding: fill with 1000, then one sample 0 -> out_i = 937 (truncate) or 938 (MAF_ROUND_EN). A single sample -8 into an empty window gives -1 (truncate) or 0 (round).
- Gapped input: in_valid every third cycle, 16 samples of 32 -> out_valid only on accept cycles. Outputs hold between accepts; final out_i = 32.
- Clear collision: after FULL, assert clear and in_valid together with in_i=500 -> no out_valid. primed goes 0; the next sample 160 gives out_i = 10.
- Async reset mid-run: assert rst between edges during FILL -> outputs and primed go 0 before the next edge. The stream restarts correctly after release.
